sha256_ctrl_fsm: RTL and testbench

SHA256_CTRL_FSM -- requirements
Module: sha256_ctrl_fsm

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_ctrl_fsm.sv | 101 ++++++++++
 tb/tb_sha256_ctrl_fsm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: control FSM state encoding and block/round sizes.
package sha256_pkg;

  localparam int NUM_WORDS  = 16;
  localparam int NUM_ROUNDS = 64;

  localparam logic [6:0] J_LAST_WORD  = 7'(NUM_WORDS - 1);
  localparam logic [6:0] J_LAST_ROUND = 7'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sha256_ctrl_fsm.sv
// SHA-256 block sequencer: loads 16 message words, runs 64 rounds, folds the
// result into H, and pulses done after the final block of a message.
module sha256_ctrl_fsm
  import sha256_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       start,
  input  logic       first_block,
  input  logic       last_block,
  input  logic       i_valid,
  input  logic       abort,
  input  logic [6:0] j,
  output logic       in_ready,
  output logic       load_w,
  output logic       clr_j,
  output logic       cnt_j_en,
  output logic       init_hash,
  output logic       round_en,
  output logic       update_hash,
  output logic       busy,
  output logic       done
);

  state_e state_q, state_d;
  logic   last_q,  last_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    in_ready    = 1'b0;
    load_w      = 1'b0;
    clr_j       = 1'b0;
    cnt_j_en    = 1'b0;
    init_hash   = 1'b0;
    round_en    = 1'b0;
    update_hash = 1'b0;
    done        = 1'b0;

    // Abort wins over everything once a message is in flight.
    if (state_q != S_IDLE && abort) begin
      clr_j   = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            clr_j     = 1'b1;
            init_hash = first_block;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          in_ready = 1'b1;
          if (i_valid) begin
            load_w = 1'b1;
            if (j == J_LAST_WORD) begin
              clr_j   = 1'b1;
              last_d  = last_block;
              state_d = S_ROUND;
            end else begin
              cnt_j_en = 1'b1;
            end
          end
        end
        S_ROUND: begin
          round_en = 1'b1;
          if (j == J_LAST_ROUND) begin
            clr_j   = 1'b1;
            state_d = S_UPDATE;
          end else begin
            cnt_j_en = 1'b1;
          end
        end
        // j was cleared leaving ROUND, so a following block starts at word 0.
        S_UPDATE: begin
          update_hash = 1'b1;
          state_d     = last_q ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_ctrl_fsm.sv
// Directed bench for sha256_ctrl_fsm with a local j counter closing the loop.
module tb_sha256_ctrl_fsm;

  logic       clk, rst_n;
  logic       start, first_block, last_block, i_valid, abort;
  logic [6:0] j;
  logic       in_ready, load_w, clr_j, cnt_j_en, init_hash, round_en;
  logic       update_hash, busy, done;

  int checks = 0;
  int errors = 0;

  sha256_ctrl_fsm dut (
    .i_clk(clk), .i_rst(rst_n), .start(start), .first_block(first_block),
    .last_block(last_block), .i_valid(i_valid), .abort(abort), .j(j),
    .in_ready(in_ready), .load_w(load_w), .clr_j(clr_j), .cnt_j_en(cnt_j_en),
    .init_hash(init_hash), .round_en(round_en), .update_hash(update_hash),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared j counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        j <= 7'd0;
    else if (clr_j)    j <= 7'd0;
    else if (cnt_j_en) j <= j + 7'd1;
  end

  wire [8:0] outs = {in_ready, load_w, clr_j, cnt_j_en, init_hash,
                     round_en, update_hash, busy, done};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle invariants.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (clr_j && cnt_j_en) begin
        errors++;
        $display("FAIL clr_cnt_overlap: clr_j=%0b cnt_j_en=%0b expected not both", clr_j, cnt_j_en);
      end
      if (done && done_prev) begin
        errors++;
        $display("FAIL done_two_cycles: done=%0b prev=%0b expected single pulse", done, done_prev);
      end
      if (j > 7'd63) begin
        errors++;
        $display("FAIL j_range: j=%0d expected <=63", j);
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  typedef struct {
    string name;
    logic  fb;
    int    nblk;
    int    stall_j;
    int    stall_len;
    int    exp_done;
    int    exp_loads;
    int    exp_rounds;
    int    exp_upds;
    int    exp_inits;
  } vec_t;

  // Called aligned to posedge+1 with the FSM idle; returns on the cycle after done.
  task automatic run_msg(input logic fb, input int nblk, input int stall_j,
                         input int stall_len, output int done_cyc, output int loads,
                         output int rounds, output int upds, output int inits,
                         output int jbad, output int vbad);
    int cyc = 0;
    int stall_rem = 0;
    done_cyc = -1; loads = 0; rounds = 0; upds = 0; inits = 0; jbad = 0; vbad = 0;
    start = 1'b1; first_block = fb; i_valid = 1'b1; abort = 1'b0;
    last_block = (nblk == 1);
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clk);
      if (load_w) begin
        if (int'(j) != loads % 16) jbad++;
        if (!i_valid) vbad++;
        if (stall_j >= 0 && int'(j) == stall_j && upds == 0) stall_rem = stall_len;
        loads++;
      end
      if (round_en)    rounds++;
      if (update_hash) upds++;
      if (init_hash)   inits++;
      if (done)        done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      i_valid = (stall_rem == 0);
      if (stall_rem > 0) stall_rem--;
      last_block = (upds == nblk - 1);
    end
    i_valid = 1'b0;
    last_block = 1'b0;
  endtask

  vec_t tbl[4];
  int   dc, nl, nr, nu, ni, jb, vb, k;

  initial begin
    tbl[0] = '{"single",     1'b1, 1, -1, 0, 82,  16, 64,  1, 1};
    tbl[1] = '{"stall3",     1'b1, 1,  5, 3, 85,  16, 64,  1, 1};
    tbl[2] = '{"two_blocks", 1'b1, 2, -1, 0, 163, 32, 128, 2, 1};
    tbl[3] = '{"cont_msg",   1'b0, 1, -1, 0, 82,  16, 64,  1, 0};

    rst_n = 1'b0; start = 1'b0; first_block = 1'b0; last_block = 1'b0;
    i_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("reset_outs", int'(outs), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", int'(outs), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_msg(tbl[i].fb, tbl[i].nblk, tbl[i].stall_j, tbl[i].stall_len,
              dc, nl, nr, nu, ni, jb, vb);
      chk({tbl[i].name, "_done_cycle"}, dc, tbl[i].exp_done);
      chk({tbl[i].name, "_load_w"},     nl, tbl[i].exp_loads);
      chk({tbl[i].name, "_round_en"},   nr, tbl[i].exp_rounds);
      chk({tbl[i].name, "_update"},     nu, tbl[i].exp_upds);
      chk({tbl[i].name, "_init_hash"},  ni, tbl[i].exp_inits);
      chk({tbl[i].name, "_j_at_load"},  jb, 0);
      chk({tbl[i].name, "_load_no_vld"}, vb, 0);
      chk({tbl[i].name, "_idle_after"}, int'({busy, done}), 0);
      repeat (2) @(posedge clk); #1;
    end

    // Abort at ROUND j==30.
    start = 1'b1; first_block = 1'b1; last_block = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 200 && !(round_en && j == 7'd30)) begin
      @(posedge clk); #1; k++;
    end
    chk("abort_reached_j30", int'(round_en && j == 7'd30), 1);
    abort = 1'b1; #1;
    chk("abort_clr_j",    int'(clr_j), 1);
    chk("abort_suppress", int'({round_en, cnt_j_en, update_hash, done, load_w}), 0);
    chk("abort_busy_cur", int'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_outs", int'(outs), 0);
    nu = 0; dc = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (update_hash) nu++;
      if (done || busy) dc++;
    end
    chk("abort_no_update", nu, 0);
    chk("abort_no_done_busy", dc, 0);
    @(posedge clk); #1;

    // Async reset in LOAD at j==9.
    start = 1'b1; first_block = 1'b1; last_block = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 50 && !(in_ready && j == 7'd9)) begin
      @(posedge clk); #1; k++;
    end
    chk("rst_reached_j9", int'(in_ready && j == 7'd9), 1);
    i_valid = 1'b0; last_block = 1'b0;
    rst_n = 1'b0; #1;
    chk("rst_mid_outs", int'(outs), 0);
    chk("rst_mid_j", int'(j), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dc = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (outs != 9'd0) dc++;
    end
    chk("rst_quiet_after", dc, 0);
    @(posedge clk); #1;
    run_msg(1'b1, 1, -1, 0, dc, nl, nr, nu, ni, jb, vb);
    chk("rst_rerun_done_cycle", dc, 82);
    chk("rst_rerun_load_w", nl, 16);
    chk("rst_rerun_j_at_load", jb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
